// File: rtl/multi_region_monitor_pkg.sv
// multi_region_monitor_pkg: shared FSM encoding and default trusted-code/reset-vector constants
package multi_region_monitor_pkg;
   typedef enum logic {RUN = 1'b0, KILL = 1'b1} state_e;
   localparam logic [15:0] TCB_BASE_DEF      = 16'hA000;
   localparam logic [15:0] TCB_SIZE_DEF      = 16'h4000;
   localparam logic [15:0] RESET_HANDLER_DEF = 16'h0000;
   localparam int          HOLD_CYC_DEF      = 4;
endpackage

// File: rtl/multi_region_monitor_if.sv
// multi_region_monitor_if: CPU/DMA write buses, region config and violation report
interface multi_region_monitor_if #(
   parameter int ADDR_W = 16,
   parameter int N_REG  = 4
);
   logic [ADDR_W-1:0]       pc;
   logic [ADDR_W-1:0]       data_addr;
   logic                    data_en;
   logic [ADDR_W-1:0]       dma_addr;
   logic                    dma_en;
   logic [N_REG*ADDR_W-1:0] reg_min;
   logic [N_REG*ADDR_W-1:0] reg_max;
   logic [N_REG-1:0]        reg_en;
   logic                    reset;
   logic [N_REG-1:0]        viol_reg;
   logic [ADDR_W-1:0]       viol_addr;
   logic                    viol_dma;
   logic [7:0]              viol_cnt;
   modport master (
      output pc, data_addr, data_en, dma_addr, dma_en, reg_min, reg_max, reg_en,
      input  reset, viol_reg, viol_addr, viol_dma, viol_cnt
   );
   modport slave (
      input  pc, data_addr, data_en, dma_addr, dma_en, reg_min, reg_max, reg_en,
      output reset, viol_reg, viol_addr, viol_dma, viol_cnt
   );
endinterface

// File: rtl/region_cmp.sv
// region_cmp: inclusive unsigned bounds check of one region against CPU and DMA writes
module region_cmp #(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W-1:0] min_i,
   input  logic [ADDR_W-1:0] max_i,
   input  logic              en_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic              data_en_i,
   input  logic [ADDR_W-1:0] dma_addr_i,
   input  logic              dma_en_i,
   input  logic              pc_trusted_i,
   output logic              cpu_hit_o,
   output logic              dma_hit_o
);
   logic active;
   assign active    = en_i && (min_i <= max_i);
   assign cpu_hit_o = active && data_en_i && !pc_trusted_i && (data_addr_i >= min_i) && (data_addr_i <= max_i);
   assign dma_hit_o = active && dma_en_i && (dma_addr_i >= min_i) && (dma_addr_i <= max_i);
endmodule

// File: rtl/multi_region_monitor.sv
// multi_region_monitor: flags writes into protected regions and holds the CPU in reset until it re-enters the reset vector
module multi_region_monitor
   import multi_region_monitor_pkg::*;
#(
   parameter int              ADDR_W        = 16,
   parameter int              N_REG         = 4,
   parameter logic [ADDR_W-1:0] TCB_BASE      = ADDR_W'(TCB_BASE_DEF),
   parameter logic [ADDR_W-1:0] TCB_SIZE      = ADDR_W'(TCB_SIZE_DEF),
   parameter logic [ADDR_W-1:0] RESET_HANDLER = ADDR_W'(RESET_HANDLER_DEF),
   parameter int              HOLD_CYC      = HOLD_CYC_DEF
) (
   input logic                  clk,
   input logic                  rst_n,
   multi_region_monitor_if.slave bus
);
   localparam logic [7:0]        HOLD    = 8'(HOLD_CYC);
   // one extra bit so a window ending at the top of the address space does not wrap
   localparam logic [ADDR_W:0]   TCB_END = {1'b0, TCB_BASE} + {1'b0, TCB_SIZE};
   logic              pc_trusted;
   logic [N_REG-1:0]  cpu_hit;
   logic [N_REG-1:0]  dma_hit;
   logic              cpu_any;
   logic              viol;
   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [7:0]        viol_cnt_q, viol_cnt_d;
   logic [N_REG-1:0]  viol_reg_q, viol_reg_d;
   logic [ADDR_W-1:0] viol_addr_q, viol_addr_d;
   logic              viol_dma_q, viol_dma_d;
   assign pc_trusted = (bus.pc >= TCB_BASE) && ({1'b0, bus.pc} < TCB_END);
   for (genvar i = 0; i < N_REG; i++) begin : g_reg
      region_cmp #(.ADDR_W(ADDR_W)) u_cmp (
         .min_i       (bus.reg_min[i*ADDR_W +: ADDR_W]),
         .max_i       (bus.reg_max[i*ADDR_W +: ADDR_W]),
         .en_i        (bus.reg_en[i]),
         .data_addr_i (bus.data_addr),
         .data_en_i   (bus.data_en),
         .dma_addr_i  (bus.dma_addr),
         .dma_en_i    (bus.dma_en),
         .pc_trusted_i(pc_trusted),
         .cpu_hit_o   (cpu_hit[i]),
         .dma_hit_o   (dma_hit[i])
      );
   end
   assign cpu_any = |cpu_hit;
   assign viol    = cpu_any | (|dma_hit);
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      viol_cnt_d  = viol_cnt_q;
      viol_reg_d  = viol_reg_q;
      viol_addr_d = viol_addr_q;
      viol_dma_d  = viol_dma_q;
      if (state_q == RUN) begin
         if (viol) begin
            state_d     = KILL;
            cnt_d       = HOLD;
            viol_reg_d  = cpu_hit | dma_hit;
            viol_addr_d = cpu_any ? bus.data_addr : bus.dma_addr;
            viol_dma_d  = !cpu_any;
            viol_cnt_d  = (viol_cnt_q == 8'hFF) ? viol_cnt_q : viol_cnt_q + 8'd1;
         end
      end else if (viol) begin
         cnt_d = HOLD;
      end else if (cnt_q == 8'd0 && bus.pc == RESET_HANDLER) begin
         state_d = RUN;
      end else if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= KILL;
         cnt_q       <= HOLD;
         viol_cnt_q  <= '0;
         viol_reg_q  <= '0;
         viol_addr_q <= '0;
         viol_dma_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         viol_cnt_q  <= viol_cnt_d;
         viol_reg_q  <= viol_reg_d;
         viol_addr_q <= viol_addr_d;
         viol_dma_q  <= viol_dma_d;
      end
   end
   assign bus.reset     = (state_q == KILL);
   assign bus.viol_reg  = viol_reg_q;
   assign bus.viol_addr = viol_addr_q;
   assign bus.viol_dma  = viol_dma_q;
   assign bus.viol_cnt  = viol_cnt_q;
endmodule

// File: tb/tb_multi_region_monitor.sv
// tb_multi_region_monitor: directed and randomized checks against a behavioural model of the monitor
module tb_multi_region_monitor;
   localparam int AW = 16, NR = 4, HOLD = 4;
   localparam int TB = 32'hA000, TS = 32'h4000, RH = 0;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   multi_region_monitor_if #(.ADDR_W(AW), .N_REG(NR)) bus ();
   multi_region_monitor #(.ADDR_W(AW), .N_REG(NR), .HOLD_CYC(HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int checks = 0, errors = 0;
   bit m_kill, m_dma;
   int m_hold, m_cnt, m_reg, m_addr;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_kill = 1; m_hold = HOLD; m_cnt = 0; m_reg = 0; m_addr = 0; m_dma = 0;
   endtask
   task automatic model_step();
      int mask = 0, pc = int'(bus.pc), da = int'(bus.data_addr), ma = int'(bus.dma_addr);
      bit cpu_any = 0;
      bit trusted = (pc >= TB) && (pc <= TB + TS - 1);
      for (int i = 0; i < NR; i++) begin
         int lo = int'(bus.reg_min[i*AW +: AW]);
         int hi = int'(bus.reg_max[i*AW +: AW]);
         if (bus.reg_en[i] && lo <= hi) begin
            if (bus.data_en && !trusted && da >= lo && da <= hi) begin mask |= 1 << i; cpu_any = 1; end
            if (bus.dma_en && ma >= lo && ma <= hi) mask |= 1 << i;
         end
      end
      if (!m_kill) begin
         if (mask != 0) begin
            m_kill = 1; m_hold = HOLD; m_reg = mask; m_dma = !cpu_any;
            m_addr = cpu_any ? da : ma;
            if (m_cnt < 255) m_cnt++;
         end
      end else if (mask != 0) m_hold = HOLD;
      else if (m_hold == 0 && pc == RH) m_kill = 0;
      else if (m_hold > 0) m_hold--;
   endtask
   initial model_reset();
   always @(posedge clk) begin
      if (!rst_n) model_reset(); else model_step();
      #1;
      chk("m_reset", 32'(bus.reset), 32'(m_kill));
      chk("m_viol_reg", 32'(bus.viol_reg), 32'(m_reg));
      chk("m_viol_addr", 32'(bus.viol_addr), 32'(m_addr));
      chk("m_viol_dma", 32'(bus.viol_dma), 32'(m_dma));
      chk("m_viol_cnt", 32'(bus.viol_cnt), 32'(m_cnt));
   end
   task automatic idle();
      bus.data_en = 0; bus.dma_en = 0;
   endtask
   task automatic set_region(int i, int lo, int hi, bit en);
      bus.reg_min[i*AW +: AW] = 16'(lo);
      bus.reg_max[i*AW +: AW] = 16'(hi);
      bus.reg_en[i] = en;
   endtask
   task automatic drive(int pc, bit de, int da, bit me, int ma);
      bus.pc = 16'(pc); bus.data_en = de; bus.data_addr = 16'(da); bus.dma_en = me; bus.dma_addr = 16'(ma);
   endtask
   task automatic sample();
      @(posedge clk); #2;
   endtask
   task automatic recover();
      @(negedge clk);
      idle(); bus.pc = 16'(RH);
      for (int n = 0; n < 100 && bus.reset !== 1'b0; n++) @(negedge clk);
      chk("recover", 32'(bus.reset), 0);
   endtask
   initial begin
      int n;
      bus.reg_min = '0; bus.reg_max = '0; bus.reg_en = '0;
      drive(0, 0, 0, 0, 0);
      #23;
      chk("rst_reset", 32'(bus.reset), 1);
      chk("rst_cnt", 32'(bus.viol_cnt), 0);
      chk("rst_addr", 32'(bus.viol_addr), 0);
      @(negedge clk); rst_n = 1;
      repeat (HOLD) begin sample(); chk("boot_hold", 32'(bus.reset), 1); end
      sample();
      chk("boot_run", 32'(bus.reset), 0);
      chk("boot_cnt", 32'(bus.viol_cnt), 0);
      // CPU write at the inclusive upper bound from untrusted code
      @(negedge clk); set_region(0, 'h200, 'h2FF, 1); drive('h4000, 1, 'h2FF, 0, 0);
      sample();
      chk("cpu_reset", 32'(bus.reset), 1);
      chk("cpu_reg", 32'(bus.viol_reg), 1);
      chk("cpu_addr", 32'(bus.viol_addr), 'h2FF);
      chk("cpu_dma", 32'(bus.viol_dma), 0);
      chk("cpu_cnt", 32'(bus.viol_cnt), 1);
      recover();
      // trusted CPU write is exempt, DMA in the same cycle is not
      drive('hA010, 1, 'h200, 1, 'h250);
      sample();
      chk("dma_reset", 32'(bus.reset), 1);
      chk("dma_dma", 32'(bus.viol_dma), 1);
      chk("dma_addr", 32'(bus.viol_addr), 'h250);
      chk("dma_cnt", 32'(bus.viol_cnt), 2);
      @(negedge clk); idle(); bus.pc = 16'h1234;
      repeat (HOLD - 2) @(negedge clk);
      drive('h1234, 0, 0, 1, 'h280);
      sample();
      chk("ext_reset", 32'(bus.reset), 1);
      chk("ext_addr", 32'(bus.viol_addr), 'h250);
      chk("ext_cnt", 32'(bus.viol_cnt), 2);
      @(negedge clk); idle(); bus.pc = 16'(RH);
      n = 0;
      for (int k = 0; k < 50; k++) begin sample(); if (bus.reset) n++; else break; end
      chk("ext_len", 32'(n), HOLD);
      // simultaneous CPU and DMA: one event, CPU address wins, mask merges
      @(negedge clk); set_region(1, 'h220, 'h22F, 1); drive('h4000, 1, 'h210, 1, 'h220);
      sample();
      chk("both_reg", 32'(bus.viol_reg), 3);
      chk("both_addr", 32'(bus.viol_addr), 'h210);
      chk("both_dma", 32'(bus.viol_dma), 0);
      chk("both_cnt", 32'(bus.viol_cnt), 3);
      recover();
      set_region(0, 'h300, 'h200, 1); set_region(1, 0, 0, 0); drive('h4000, 1, 'h250, 1, 'h250);
      sample();
      chk("inv_bounds", 32'(bus.reset), 0);
      @(negedge clk); set_region(0, 'h200, 'h2FF, 0);
      sample();
      chk("disabled", 32'(bus.reset), 0);
      @(negedge clk); set_region(0, 'h200, 'h2FF, 1); drive('h4000, 1, 'h1FF, 1, 'h300);
      sample();
      chk("outside", 32'(bus.reset), 0);
      @(negedge clk); drive('hDFFF, 1, 'h200, 0, 0);
      sample();
      chk("tcb_top", 32'(bus.reset), 0);
      @(negedge clk); drive('hE000, 1, 'h200, 0, 0);
      sample();
      chk("tcb_past", 32'(bus.reset), 1);
      chk("tcb_past_cnt", 32'(bus.viol_cnt), 4);
      recover();
      // asynchronous reset while running must act before the next clock edge
      #3 rst_n = 0;
      #1;
      chk("async_reset", 32'(bus.reset), 1);
      chk("async_cnt", 32'(bus.viol_cnt), 0);
      chk("async_reg", 32'(bus.viol_reg), 0);
      @(negedge clk); rst_n = 1;
      recover();
      for (int c = 0; c < 3000; c++) begin
         int sel;
         @(negedge clk);
         if (c % 40 == 0)
            for (int i = 0; i < NR; i++)
               set_region(i, $urandom_range(0, 'h3FF), $urandom_range(0, 'h3FF), ($urandom % 3) != 0);
         sel = $urandom_range(0, 9);
         drive(sel < 4 ? RH : sel < 7 ? TB + $urandom_range(0, TS - 1) : $urandom_range(0, TB - 1),
               ($urandom % 4) == 0, $urandom_range(0, 'h3FF), ($urandom % 6) == 0, $urandom_range(0, 'h3FF));
      end
      recover();
      for (int i = 0; i < NR; i++) set_region(i, 0, 0, 0);
      set_region(0, 'h200, 'h2FF, 1);
      for (int k = 0; k < 260; k++) begin
         drive('h4000, 1, 'h250, 0, 0);
         recover();
      end
      chk("sat_cnt", 32'(bus.viol_cnt), 255);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
